// File: rtl/nf10_barrier_port_client.sv
// Per-port barrier client: waits for the port's expected RX packets and a quiet
// stream, then handshakes barrier_req/barrier_proceed with the global aggregator.
module nf10_barrier_port_client #(
  parameter int CNT_WIDTH     = 16,
  parameter int DRAIN_CYCLES  = 8,
  parameter int ACTIVITY_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 barrier_cmd_valid,
  input  logic [CNT_WIDTH-1:0] barrier_cmd_count,
  output logic                 barrier_cmd_ready,
  input  logic                 pkt_rx_done,
  input  logic                 stream_beat,
  output logic                 barrier_req,
  input  logic                 barrier_proceed,
  output logic                 barrier_done,
  output logic                 activity,
  output logic [7:0]           barrier_num,
  output logic                 rx_overflow
);

  localparam int QW = $clog2(DRAIN_CYCLES + 1);
  localparam int HW = $clog2(ACTIVITY_HOLD + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, REQ, RELEASE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] expected, rx_count, rx_base, rx_nxt;
  logic [QW-1:0]        quiet_cnt, quiet_nxt;
  logic [HW-1:0]        hold, hold_nxt;
  logic                 accept, release_done, ovf_evt;

  // quiet_nxt counts the current cycle too, so DRAIN exits once DRAIN_CYCLES
  // beat-free cycles have fully elapsed and barrier_req follows one cycle later.
  always_comb begin
    quiet_nxt = quiet_cnt;
    if (stream_beat)                      quiet_nxt = '0;
    else if (quiet_cnt != QW'(DRAIN_CYCLES)) quiet_nxt = quiet_cnt + 1'b1;
  end

  always_comb begin
    hold_nxt = hold;
    if (stream_beat || pkt_rx_done) hold_nxt = HW'(ACTIVITY_HOLD);
    else if (hold != '0)            hold_nxt = hold - 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    release_done = 1'b0;
    case (state)
      IDLE: if (barrier_cmd_valid) begin
        accept    = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: if (rx_count >= expected && quiet_nxt == QW'(DRAIN_CYCLES))
        state_nxt = REQ;
      REQ: if (barrier_proceed) state_nxt = RELEASE;
      RELEASE: if (!barrier_proceed) begin
        release_done = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A packet landing on the clear cycle counts toward the next epoch.
  always_comb begin
    rx_base = release_done ? '0 : rx_count;
    rx_nxt  = rx_base;
    if (pkt_rx_done && rx_base != '1) rx_nxt = rx_base + 1'b1;
  end

  // expected is 0 in IDLE, so any packet there is already one too many.
  assign ovf_evt = pkt_rx_done && (state == IDLE || rx_count >= expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      expected          <= '0;
      rx_count          <= '0;
      quiet_cnt         <= '0;
      hold              <= '0;
      barrier_cmd_ready <= 1'b1;
      barrier_req       <= 1'b0;
      barrier_done      <= 1'b0;
      activity          <= 1'b0;
      barrier_num       <= '0;
      rx_overflow       <= 1'b0;
    end else begin
      state             <= state_nxt;
      quiet_cnt         <= quiet_nxt;
      hold              <= hold_nxt;
      rx_count          <= rx_nxt;
      if (accept)            expected <= barrier_cmd_count;
      else if (release_done) expected <= '0;
      if (ovf_evt)           rx_overflow <= 1'b1;
      if (release_done)      barrier_num <= barrier_num + 1'b1;
      barrier_cmd_ready <= (state_nxt == IDLE);
      barrier_req       <= (state_nxt == REQ);
      barrier_done      <= release_done;
      activity          <= (hold_nxt != '0);
    end
  end

endmodule

// File: tb/tb_nf10_barrier_port_client.sv
// Directed bench for nf10_barrier_port_client: a vector table for the main
// barrier timeline plus hand-written sequences for the multi-cycle corners.
module tb_nf10_barrier_port_client;

  logic        clk = 1'b0;
  logic        reset;
  logic        barrier_cmd_valid;
  logic [15:0] barrier_cmd_count;
  logic        barrier_cmd_ready;
  logic        pkt_rx_done;
  logic        stream_beat;
  logic        barrier_req;
  logic        barrier_proceed;
  logic        barrier_done;
  logic        activity;
  logic [7:0]  barrier_num;
  logic        rx_overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  nf10_barrier_port_client #(.CNT_WIDTH(16), .DRAIN_CYCLES(8), .ACTIVITY_HOLD(16)) dut (
    .clk(clk), .reset(reset),
    .barrier_cmd_valid(barrier_cmd_valid), .barrier_cmd_count(barrier_cmd_count),
    .barrier_cmd_ready(barrier_cmd_ready), .pkt_rx_done(pkt_rx_done),
    .stream_beat(stream_beat), .barrier_req(barrier_req),
    .barrier_proceed(barrier_proceed), .barrier_done(barrier_done),
    .activity(activity), .barrier_num(barrier_num), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (barrier_done) done_cnt++;

  typedef struct {
    logic        cmd_valid;
    logic [15:0] cmd_count;
    logic        pkt, beat, proceed;
    logic        exp_req, exp_done, exp_ready, exp_act;
    logic [7:0]  exp_num;
  } vec_t;

  vec_t tv[33];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic get_sig(input int sel);
    return (sel == 0) ? barrier_req : barrier_done;
  endfunction

  task automatic wait_sig(input int sel, input int maxc, input string nm);
    int n = 0;
    while (get_sig(sel) !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk(nm, int'(get_sig(sel)), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic do_release(input string nm);
    barrier_proceed = 1'b1;
    step();
    barrier_proceed = 1'b0;
    wait_sig(1, 5, nm);
  endtask

  initial begin
    int d0;
    reset = 1'b1; barrier_cmd_valid = 0; barrier_cmd_count = 0;
    pkt_rx_done = 0; stream_beat = 0; barrier_proceed = 0;
    step();
    do_reset();

    // Main timeline: cmd at cycle 0, packets at 5/9/12, beats 1..12.
    for (int i = 0; i < 33; i++) begin
      tv[i].cmd_valid = (i == 0);
      tv[i].cmd_count = 16'd3;
      tv[i].pkt       = (i == 5 || i == 9 || i == 12);
      tv[i].beat      = (i >= 1 && i <= 12);
      tv[i].proceed   = (i >= 25 && i <= 29);
      tv[i].exp_req   = (i >= 21 && i <= 25);
      tv[i].exp_done  = (i == 31);
      tv[i].exp_ready = (i == 0 || i >= 31);
      tv[i].exp_act   = (i >= 2 && i <= 28);
      tv[i].exp_num   = (i >= 31) ? 8'd1 : 8'd0;
    end
    chk("reset_ovf", rx_overflow, 0);
    for (int i = 0; i < 33; i++) begin
      barrier_cmd_valid = tv[i].cmd_valid;
      barrier_cmd_count = tv[i].cmd_count;
      pkt_rx_done       = tv[i].pkt;
      stream_beat       = tv[i].beat;
      barrier_proceed   = tv[i].proceed;
      chk($sformatf("t1_req[%0d]", i),   barrier_req,       tv[i].exp_req);
      chk($sformatf("t1_done[%0d]", i),  barrier_done,      tv[i].exp_done);
      chk($sformatf("t1_ready[%0d]", i), barrier_cmd_ready, tv[i].exp_ready);
      chk($sformatf("t1_act[%0d]", i),   activity,          tv[i].exp_act);
      chk($sformatf("t1_num[%0d]", i),   barrier_num,       tv[i].exp_num);
      step();
    end
    chk("t1_ovf", rx_overflow, 0);

    // Zero-count command with no traffic, starting from a fresh quiet counter.
    do_reset();
    chk("t2_num_rst", barrier_num, 0);
    barrier_cmd_valid = 1; barrier_cmd_count = 0;
    step();
    barrier_cmd_valid = 0;
    chk("t2_ready_drain", barrier_cmd_ready, 0);
    repeat (6) step();
    chk("t2_req_early", barrier_req, 0);
    step();
    chk("t2_req_rise", barrier_req, 1);
    barrier_proceed = 1;
    step();
    barrier_proceed = 0;
    chk("t2_req_fall", barrier_req, 0);
    step();
    chk("t2_done", barrier_done, 1);
    chk("t2_num", barrier_num, 1);
    step();
    chk("t2_done_pulse", barrier_done, 0);

    // Overflow: expect 2, receive 3.
    barrier_cmd_valid = 1; barrier_cmd_count = 2; stream_beat = 1;
    step();
    barrier_cmd_valid = 0; pkt_rx_done = 1;
    step(); step();
    chk("t3_ovf_before", rx_overflow, 0);
    step();
    pkt_rx_done = 0; stream_beat = 0;
    chk("t3_ovf_set", rx_overflow, 1);
    wait_sig(0, 20, "t3_req");
    do_release("t3_done");
    chk("t3_num", barrier_num, 2);

    // Beat during REQ, then a packet on the clear cycle.
    barrier_cmd_valid = 1; barrier_cmd_count = 0;
    step();
    barrier_cmd_valid = 0;
    wait_sig(0, 20, "t4_req");
    stream_beat = 1;
    step();
    stream_beat = 0;
    chk("t4_req_hold", barrier_req, 1);
    chk("t4_act_first", activity, 1);
    repeat (15) step();
    chk("t4_act_last", activity, 1);
    chk("t4_req_hold2", barrier_req, 1);
    step();
    chk("t4_act_off", activity, 0);
    barrier_proceed = 1;
    step();
    barrier_proceed = 0; pkt_rx_done = 1;
    chk("t4_release", barrier_req, 0);
    step();
    pkt_rx_done = 0;
    chk("t4_done", barrier_done, 1);
    chk("t4_num", barrier_num, 3);
    // The carried packet alone satisfies a count of 1.
    barrier_cmd_valid = 1; barrier_cmd_count = 1;
    step();
    barrier_cmd_valid = 0;
    step();
    chk("t4_carry_req", barrier_req, 1);
    chk("t4_ovf_sticky", rx_overflow, 1);
    do_release("t4_carry_done");
    chk("t4_num2", barrier_num, 4);

    // Proceed already high on entry to REQ.
    barrier_proceed = 1; barrier_cmd_valid = 1; barrier_cmd_count = 0;
    step();
    barrier_cmd_valid = 0;
    step();
    chk("t5_req_one", barrier_req, 1);
    step();
    chk("t5_req_drop", barrier_req, 0);
    barrier_proceed = 0;
    step();
    chk("t5_done", barrier_done, 1);
    chk("t5_num", barrier_num, 5);

    // Reset while in REQ.
    barrier_cmd_valid = 1; barrier_cmd_count = 0;
    step();
    barrier_cmd_valid = 0;
    wait_sig(0, 20, "t6_req");
    reset = 1;
    step();
    reset = 0;
    chk("t6_req_rst", barrier_req, 0);
    chk("t6_ready_rst", barrier_cmd_ready, 1);
    chk("t6_num_rst", barrier_num, 0);
    chk("t6_ovf_rst", rx_overflow, 0);
    chk("t6_done_rst", barrier_done, 0);

    // 256 back-to-back barriers with cmd_valid held throughout.
    d0 = done_cnt;
    barrier_cmd_valid = 1; barrier_cmd_count = 0;
    for (int i = 0; i < 256; i++) begin
      wait_sig(0, 20, "t7_req");
      chk("t7_ready_busy", barrier_cmd_ready, 0);
      do_release("t7_done");
      if (i == 254) chk("t7_num_255", barrier_num, 255);
      if (i == 255) barrier_cmd_valid = 0;
      step();
    end
    chk("t7_num_wrap", barrier_num, 0);
    repeat (12) step();
    chk("t7_done_count", done_cnt - d0, 256);
    chk("t7_idle_req", barrier_req, 0);
    chk("t7_idle_ready", barrier_cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
